// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Sequencing controller for the fetch stage. Arbitrates between the boot
// hold-off after reset, EX-stage branch redirects, load-use stalls and debug
// halt/resume. It produces the PC-write/PC-select controls, the redirect
// target, the IF/ID load/flush and the ID/EX bubble. It also keeps saturating
// stall and redirect counters for performance monitoring.
//
// State (FSM, flush and boot counters, perf counters) is registered. The
// control outputs are combinational from the state and the current inputs,
// so they take effect on the next rising clock edge.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   asynchronous reset, active low
//   branch_taken     in   EX-stage branch/jump resolved taken
//   branch_target    in   redirect address, qualified by branch_taken
//   load_use_hazard  in   one-cycle stall request from the hazard unit
//   halt_req         in   debug halt request (level)
//   resume           in   debug resume pulse
//   pc_write         out  PC counter update enable
//   pc_src           out  1 selects branch_pc as the next PC
//   branch_pc        out  redirect target (0 when no redirect is issued)
//   if_id_write      out  IF/ID register load enable
//   if_id_flush      out  IF/ID register clear (inserts a NOP)
//   id_ex_bubble     out  ID/EX control clear
//   halted           out  fetch is halted for debug
//   stall_count      out  saturating count of load-use stall cycles
//   redirect_count   out  saturating count of accepted redirects
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int BOOT_CYCLES  = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             load_use_hazard,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             pc_src,
  output logic [31:0]      branch_pc,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] redirect_count
);

  // Boot counter counts 0..BOOT_CYCLES-1; flush counter holds 0..FLUSH_CYCLES-1.
  localparam int BOOT_W  = (BOOT_CYCLES  > 2) ? $clog2(BOOT_CYCLES)  : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // With no boot hold-off the controller leaves reset directly in RUN.
  localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? ST_RUN : ST_BOOT;

  state_t             r_state;
  logic [BOOT_W-1:0]  r_boot_cnt;
  logic [FLUSH_W-1:0] r_flush_left;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_redirect_cnt;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RESET_STATE;
      r_boot_cnt     <= '0;
      r_flush_left   <= '0;
      r_stall_cnt    <= '0;
      r_redirect_cnt <= '0;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          if (r_boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) r_state <= ST_RUN;
          else                                        r_boot_cnt <= r_boot_cnt + 1'b1;
        end

        ST_RUN: begin
          if (branch_taken) begin
            if (r_redirect_cnt != '1) r_redirect_cnt <= r_redirect_cnt + 1'b1;
            // The redirect cycle itself is the first flush cycle; FLUSH covers
            // the remainder.
            if (FLUSH_CYCLES > 1) begin
              r_state      <= ST_FLUSH;
              r_flush_left <= FLUSH_W'(FLUSH_CYCLES - 1);
            end
          end else if (load_use_hazard) begin
            if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
          end else if (halt_req) begin
            r_state <= ST_HALT;
          end
        end

        ST_FLUSH: begin
          r_flush_left <= r_flush_left - 1'b1;
          if (r_flush_left == FLUSH_W'(1)) r_state <= ST_RUN;
        end

        ST_HALT: begin
          // A resume coinciding with a still-active halt request is ignored.
          if (resume && !halt_req) r_state <= ST_RUN;
        end

        default: r_state <= RESET_STATE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    branch_pc    = '0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;

    // Gating on reset makes the outputs reset values independent of the
    // reset state chosen for BOOT_CYCLES == 0.
    if (!reset) begin
      if_id_flush = 1'b1;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          if_id_flush = 1'b1;
        end

        ST_RUN: begin
          if (branch_taken) begin
            pc_src      = 1'b1;
            branch_pc   = branch_target;
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (load_use_hazard) begin
            id_ex_bubble = 1'b1;
          end else begin
            // Normal fetch, also on the cycle a halt request is accepted.
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end

        ST_FLUSH: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
        end

        ST_HALT: begin
          if_id_flush = 1'b1;
          halted      = 1'b1;
        end

        default: begin
          if_id_flush = 1'b1;
        end
      endcase
    end
  end

  assign stall_count    = r_stall_cnt;
  assign redirect_count = r_redirect_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Scoreboard bench for fetch_ctrl. The stimulus process drives one input
// vector per cycle just after the rising edge, asks a behavioural model for
// the expected outputs and pushes them into a queue. The monitor samples the
// DUT on the falling edge, pops one expectation and compares every output.
// Directed scenarios come first, followed by biased random traffic.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int BOOT_CYCLES  = 4;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             branch_taken = 1'b0;
  logic [31:0]      branch_target = '0;
  logic             load_use_hazard = 1'b0;
  logic             halt_req = 1'b0;
  logic             resume = 1'b0;
  logic             pc_write;
  logic             pc_src;
  logic [31:0]      branch_pc;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] redirect_count;

  fetch_ctrl #(
    .BOOT_CYCLES  (BOOT_CYCLES),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .load_use_hazard (load_use_hazard),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_write        (pc_write),
    .pc_src          (pc_src),
    .branch_pc       (branch_pc),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .halted          (halted),
    .stall_count     (stall_count),
    .redirect_count  (redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pc_write;
    logic        pc_src;
    logic [31:0] branch_pc;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        halted;
    int          stalls;
    int          redirects;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the pipeline is in boot while boot cycles remain, in
  // flush while flush cycles remain, otherwise halted or running.
  // ---------------------------------------------------------------------------
  int m_boot_left  = BOOT_CYCLES;
  int m_flush_left = 0;
  bit m_halted     = 1'b0;
  int m_stalls     = 0;
  int m_redirects  = 0;

  function automatic exp_t model_step(bit rst_n, bit br, logic [31:0] tgt,
                                      bit luh, bit hr, bit rs);
    exp_t e;
    e = '{pc_write: 1'b0, pc_src: 1'b0, branch_pc: 32'h0, if_id_write: 1'b0,
          if_id_flush: 1'b0, id_ex_bubble: 1'b0, halted: 1'b0,
          stalls: m_stalls, redirects: m_redirects};
    if (!rst_n) begin
      m_boot_left  = BOOT_CYCLES;
      m_flush_left = 0;
      m_halted     = 1'b0;
      m_stalls     = 0;
      m_redirects  = 0;
      e.stalls      = 0;
      e.redirects   = 0;
      e.if_id_flush = 1'b1;
    end else if (m_boot_left > 0) begin
      e.if_id_flush = 1'b1;
      m_boot_left--;
    end else if (m_flush_left > 0) begin
      e.pc_write    = 1'b1;
      e.if_id_write = 1'b1;
      e.if_id_flush = 1'b1;
      m_flush_left--;
    end else if (m_halted) begin
      e.if_id_flush = 1'b1;
      e.halted      = 1'b1;
      if (rs && !hr) m_halted = 1'b0;
    end else if (br) begin
      e.pc_src      = 1'b1;
      e.branch_pc   = tgt;
      e.pc_write    = 1'b1;
      e.if_id_write = 1'b1;
      e.if_id_flush = 1'b1;
      if (m_redirects < CNT_MAX) m_redirects++;
      m_flush_left = FLUSH_CYCLES - 1;
    end else if (luh) begin
      e.id_ex_bubble = 1'b1;
      if (m_stalls < CNT_MAX) m_stalls++;
    end else begin
      e.pc_write    = 1'b1;
      e.if_id_write = 1'b1;
      if (hr) m_halted = 1'b1;
    end
    return e;
  endfunction

  // One stimulus cycle: drive just after the rising edge, queue the expectation.
  task automatic cycle(input bit rst_n, input bit br, input logic [31:0] tgt,
                       input bit luh, input bit hr, input bit rs);
    @(posedge clk);
    #1;
    reset           = rst_n;
    branch_taken    = br;
    branch_target   = tgt;
    load_use_hazard = luh;
    halt_req        = hr;
    resume          = rs;
    exp_q.push_back(model_step(rst_n, br, tgt, luh, hr, rs));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pc_write",       32'(pc_write),       32'(e.pc_write));
      check("pc_src",         32'(pc_src),         32'(e.pc_src));
      check("branch_pc",      branch_pc,           e.branch_pc);
      check("if_id_write",    32'(if_id_write),    32'(e.if_id_write));
      check("if_id_flush",    32'(if_id_flush),    32'(e.if_id_flush));
      check("id_ex_bubble",   32'(id_ex_bubble),   32'(e.id_ex_bubble));
      check("halted",         32'(halted),         32'(e.halted));
      check("stall_count",    32'(stall_count),    32'(e.stalls));
      check("redirect_count", 32'(redirect_count), 32'(e.redirects));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit hr_r;

    // Reset held, then boot hold-off and some free-running fetch.
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h1234, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'h5555, 1'b1, 1'b1, 1'b0);  // requests ignored in boot
    idle(BOOT_CYCLES + 2);

    // Single redirect followed by its flush shadow.
    cycle(1'b1, 1'b1, 32'h0000_0040, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Single load-use stall, then stall coincident with a redirect.
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Back-to-back branches: the second lands in the flush shadow.
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Stall deferring a halt, halt, resume-with-halt, then plain resume.
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Long stall saturates stall_count, then reset drops mid-stall.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Biased random traffic with an occasional reset.
    hr_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      bit          rst_n;
      bit          br;
      bit          luh;
      bit          rs;
      logic [31:0] tgt;
      rst_n = ($urandom_range(99) != 0);
      br    = ($urandom_range(99) < 20);
      luh   = ($urandom_range(99) < 25);
      rs    = ($urandom_range(99) < 20);
      tgt   = $urandom;
      if ($urandom_range(99) < 12) hr_r = ~hr_r;
      cycle(rst_n, br, tgt, luh, hr_r, rs);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
